// File: rtl/serial_code_lock.sv
// Serial-entry code lock: CODE_LEN-bit code shifted in one bit per strobe, timed release,
// consecutive-failure alarm and idle timeout. Define PROG_CODE_EN to allow reprogramming the code while open.
module serial_code_lock #(
   parameter int                  CODE_LEN    = 3,
   parameter logic [CODE_LEN-1:0] SECRET      = 3'b010,
   parameter int                  MAX_FAIL    = 3,
   parameter int                  OPEN_CYCLES = 4,
   parameter int                  TIMEOUT     = 16,
   localparam int                 FW          = $clog2(MAX_FAIL + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                code,
   input  logic                code_vld,
   input  logic                clr_alarm,
`ifdef PROG_CODE_EN
   input  logic                prog_we,
   input  logic [CODE_LEN-1:0] new_code,
`endif
   output logic                openLock,
   output logic                alarm,
   output logic [FW-1:0]       fail_cnt,
   output logic                entry_busy
);

   localparam int BW = $clog2(CODE_LEN);
   localparam int IW = $clog2(TIMEOUT);
   localparam int OW = $clog2(OPEN_CYCLES + 1);

   localparam logic [BW-1:0] LAST_BIT  = BW'(CODE_LEN - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
   localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYCLES - 1);
   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
   localparam logic [FW-1:0] FAIL_SAT  = FW'(MAX_FAIL);

   typedef enum logic [1:0] {IDLE, ENTRY, OPEN, ALARM} lockStateT;

   lockStateT             state;
   logic [CODE_LEN-2:0]   shreg;
   logic [BW-1:0]         bitCnt;
   logic [IW-1:0]         idleCnt;
   logic [OW-1:0]         openCnt;
   logic [CODE_LEN-1:0]   storedCode;
   logic [CODE_LEN-1:0]   candidate;

   // shreg is zero whenever the FSM sits in IDLE, so the same shift serves the first bit.
   assign candidate = {shreg, code};

`ifndef PROG_CODE_EN
   assign storedCode = SECRET;
`endif

   // NOTE: every state bit lives in this one block and uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bitCnt     <= '0;
         idleCnt    <= '0;
         openCnt    <= '0;
         openLock   <= 1'b0;
         alarm      <= 1'b0;
         fail_cnt   <= '0;
         entry_busy <= 1'b0;
`ifdef PROG_CODE_EN
         // NOTE: the stored code is state like any other register; reset must restore SECRET.
         storedCode <= SECRET;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (code_vld) begin
                  shreg      <= candidate[CODE_LEN-2:0];
                  bitCnt     <= BW'(1);
                  idleCnt    <= '0;
                  entry_busy <= 1'b1;
                  state      <= ENTRY;
               end
            end

            ENTRY: begin
               if (code_vld) begin
                  idleCnt <= '0;
                  if (bitCnt == LAST_BIT) begin
                     shreg      <= '0;
                     bitCnt     <= '0;
                     entry_busy <= 1'b0;
                     if (candidate == storedCode) begin
                        state    <= OPEN;
                        openLock <= 1'b1;
                        openCnt  <= '0;
                        fail_cnt <= '0;
                     end else if (fail_cnt >= FAIL_LAST) begin
                        state    <= ALARM;
                        alarm    <= 1'b1;
                        fail_cnt <= FAIL_SAT;
                     end else begin
                        state    <= IDLE;
                        fail_cnt <= fail_cnt + 1'b1;
                     end
                  end else begin
                     shreg  <= candidate[CODE_LEN-2:0];
                     bitCnt <= bitCnt + 1'b1;
                  end
               end else if (idleCnt == IDLE_LAST) begin
                  // Abandoned partial entry: discard bits without counting a failure.
                  state      <= IDLE;
                  shreg      <= '0;
                  bitCnt     <= '0;
                  idleCnt    <= '0;
                  entry_busy <= 1'b0;
               end else begin
                  idleCnt <= idleCnt + 1'b1;
               end
            end

            OPEN: begin
`ifdef PROG_CODE_EN
               if (prog_we) storedCode <= new_code;
`endif
               if (openCnt == OPEN_LAST) begin
                  state    <= IDLE;
                  openLock <= 1'b0;
                  openCnt  <= '0;
               end else begin
                  openCnt <= openCnt + 1'b1;
               end
            end

            ALARM: begin
               if (clr_alarm) begin
                  state    <= IDLE;
                  alarm    <= 1'b0;
                  fail_cnt <= '0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
